node_act_buffer: RTL and testbench

- Downstream neighbour of the node compute stage; sits between one layer's node outputs and the next layer's input stream.
- Accepts node results one at a time and requantizes each one: arithmetic shift, optional ReLU, then saturation to DW.
- Collects N_NODES results into a register buffer, then streams them out in index order as the next layer's prev_outputs, with valid/ready backpressure.
- Single buffer, so fill and drain alternate.

---
 rtl/cnn_pkg.sv | 27 ++
 rtl/act_requant.sv | 29 ++
 rtl/node_act_buffer.sv | 108 ++++++++++
 tb/tb_node_act_buffer.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN activation path.
// Holds the drain/fill state type and a width-parametric signed clamp.
package cnn_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } act_state_t;

    localparam int DW_DEFAULT = 16;

    // Clamp a wide signed value into the range of a w-bit signed number (w < 64).
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/act_requant.sv
// Combinational requantizer: arithmetic right shift, optional ReLU, then
// saturation of the node result into the activation width.
module act_requant
    import cnn_pkg::*;
#(
    parameter int ACC_W   = 16,
    parameter int DW      = DW_DEFAULT,
    parameter int SHIFT   = 0,
    parameter bit RELU_EN = 1'b1
) (
    input  logic signed [ACC_W-1:0] x,
    output logic signed [DW-1:0]    y
);

    logic signed [ACC_W-1:0] shifted;
    logic signed [63:0]      wide;

    // NOTE: every variable written in always_comb gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        shifted = x >>> SHIFT;
        wide    = 64'(shifted);
        if (RELU_EN && (wide < 0)) begin
            wide = '0;
        end
        y = DW'(sat_signed(wide, DW));
    end

endmodule

// File: rtl/node_act_buffer.sv
// Collects one layer of requantized node results, then streams them out in
// index order with valid/ready backpressure; fill and drain alternate.
module node_act_buffer
    import cnn_pkg::*;
#(
    parameter int N_NODES = 16,
    parameter int ACC_W   = 16,
    parameter int DW      = DW_DEFAULT,
    parameter int SHIFT   = 0,
    parameter bit RELU_EN = 1'b1,
    localparam int IDX_W  = (N_NODES > 1) ? $clog2(N_NODES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [ACC_W-1:0]        x,
    output logic                    in_ready,
    output logic                    valid_out,
    output logic signed [DW-1:0]    y,
    output logic [IDX_W-1:0]        y_idx,
    output logic                    y_last,
    input  logic                    out_ready,
    output logic                    layer_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NODES - 1);

    act_state_t               state;
    act_state_t               state_next;
    logic [IDX_W-1:0]         wr_idx;
    logic [IDX_W-1:0]         rd_idx;
    logic signed [DW-1:0]     act_buf [N_NODES];
    logic signed [DW-1:0]     act_x;
    logic                     in_fire;
    logic                     out_fire;

    act_requant #(
        .ACC_W   (ACC_W),
        .DW      (DW),
        .SHIFT   (SHIFT),
        .RELU_EN (RELU_EN)
    ) u_requant (
        .x (x),
        .y (act_x)
    );

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        valid_out  = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (valid_in && (wr_idx == LAST_IDX)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                valid_out = 1'b1;
                if (out_ready && (rd_idx == LAST_IDX)) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    assign in_fire  = valid_in && in_ready;
    assign out_fire = valid_out && out_ready;

    // Outputs come straight from registered state, so they are stable under backpressure.
    assign y      = act_buf[rd_idx];
    assign y_idx  = rd_idx;
    assign y_last = valid_out && (rd_idx == LAST_IDX);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the buffer is cleared on reset so no stale layer can ever be
    // observed on y; this costs a reset mux per entry, which is acceptable at this depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx     <= '0;
            rd_idx     <= '0;
            layer_done <= 1'b0;
            for (int i = 0; i < N_NODES; i++) begin
                act_buf[i] <= '0;
            end
        end else begin
            layer_done <= out_fire && y_last;
            if (in_fire) begin
                act_buf[wr_idx] <= act_x;
                wr_idx          <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
            end
            if (out_fire) begin
                rd_idx <= y_last ? '0 : rd_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_node_act_buffer.sv
// Scoreboard bench for node_act_buffer: three instances cover the unsigned
// ReLU configuration, the signed pass-through configuration and N_NODES=1.
module tb_node_act_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance a: ACC_W=32, DW=16, SHIFT=8, N_NODES=4, RELU_EN=1
    logic        a_valid_in, a_in_ready, a_valid_out, a_y_last, a_out_ready, a_layer_done;
    logic [31:0] a_x;
    logic [15:0] a_y;
    logic [1:0]  a_y_idx;

    // Instance b: ACC_W=32, DW=16, SHIFT=0, N_NODES=4, RELU_EN=0
    logic        b_valid_in, b_in_ready, b_valid_out, b_y_last, b_out_ready, b_layer_done;
    logic [31:0] b_x;
    logic [15:0] b_y;
    logic [1:0]  b_y_idx;

    // Instance c: ACC_W=32, DW=16, SHIFT=0, N_NODES=1, RELU_EN=1
    logic        c_valid_in, c_in_ready, c_valid_out, c_y_last, c_out_ready, c_layer_done;
    logic [31:0] c_x;
    logic [15:0] c_y;
    logic [0:0]  c_y_idx;

    node_act_buffer #(.N_NODES(4), .ACC_W(32), .DW(16), .SHIFT(8), .RELU_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .valid_in(a_valid_in), .x(a_x), .in_ready(a_in_ready),
        .valid_out(a_valid_out), .y(a_y), .y_idx(a_y_idx), .y_last(a_y_last),
        .out_ready(a_out_ready), .layer_done(a_layer_done)
    );

    node_act_buffer #(.N_NODES(4), .ACC_W(32), .DW(16), .SHIFT(0), .RELU_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .valid_in(b_valid_in), .x(b_x), .in_ready(b_in_ready),
        .valid_out(b_valid_out), .y(b_y), .y_idx(b_y_idx), .y_last(b_y_last),
        .out_ready(b_out_ready), .layer_done(b_layer_done)
    );

    node_act_buffer #(.N_NODES(1), .ACC_W(32), .DW(16), .SHIFT(0), .RELU_EN(1'b1)) dut_c (
        .clk(clk), .rst(rst), .valid_in(c_valid_in), .x(c_x), .in_ready(c_in_ready),
        .valid_out(c_valid_out), .y(c_y), .y_idx(c_y_idx), .y_last(c_y_last),
        .out_ready(c_out_ready), .layer_done(c_layer_done)
    );

    typedef struct {
        logic [15:0] y;
        int          idx;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference requantization: shift, optional ReLU, clamp to 16-bit signed.
    function automatic logic [15:0] model_act(input logic [31:0] xv, input int shift, input bit relu);
        longint s;
        s = longint'($signed(xv)) >>> shift;
        if (relu && s < 0) s = 0;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return 16'(s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feeds entries first..3 into instance a and records what must come out.
    task automatic fill_a(input logic [31:0] xs[4], input logic [15:0] ys[4], input int first);
        for (int i = first; i < 4; i++) begin
            int t;
            a_valid_in = 1'b1;
            a_x        = xs[i];
            t = 0;
            while (!a_in_ready && t < 50) begin
                tick();
                t++;
            end
            if (!a_in_ready) begin
                n_checks++;
                n_fail++;
                $display("FAIL fill_timeout: in_ready=%b after %0d cycles, required 1", a_in_ready, t);
            end
            sb.push_back('{y: ys[i], idx: i});
            tick();
        end
        a_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++; if (a_valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_during_valid_out: got %b want 0", a_valid_out); end
        n_checks++; if (a_y_last !== 1'b0) begin n_fail++; $display("FAIL rst_during_y_last: got %b want 0", a_y_last); end
        rst = 1'b0;
        tick();
        n_checks++; if (a_valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid_out: got %b want 0", a_valid_out); end
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", a_in_ready); end
        n_checks++; if (a_layer_done !== 1'b0) begin n_fail++; $display("FAIL rst_layer_done: got %b want 0", a_layer_done); end
        n_checks++; if (a_y_idx !== 2'd0) begin n_fail++; $display("FAIL rst_y_idx: got %0d want 0", a_y_idx); end
        n_checks++; if (b_valid_out !== 1'b0 || c_valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid_out_bc: got %b%b want 00", b_valid_out, c_valid_out); end
    endtask

    task automatic test_requant_order();
        logic [31:0] xs[4];
        logic [15:0] ys[4];
        exp_t        e;
        xs[0] = 32'h0000_0300; xs[1] = 32'hFFFF_FF00; xs[2] = 32'h7FFF_FFFF; xs[3] = 32'h0000_0080;
        ys[0] = 16'd3;         ys[1] = 16'd0;         ys[2] = 16'h7FFF;      ys[3] = 16'd0;
        fill_a(xs, ys, 0);
        n_checks++; if (a_valid_out !== 1'b1) begin n_fail++; $display("FAIL order_latency: valid_out=%b want 1", a_valid_out); end
        n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL order_in_ready: got %b want 0", a_in_ready); end
        a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e = sb.pop_front();
            n_checks++; if (a_valid_out !== 1'b1) begin n_fail++; $display("FAIL order_valid[%0d]: got %b want 1", i, a_valid_out); end
            n_checks++; if (a_y !== e.y) begin n_fail++; $display("FAIL order_y[%0d]: got %h want %h", i, a_y, e.y); end
            n_checks++; if (a_y_idx !== 2'(e.idx)) begin n_fail++; $display("FAIL order_idx[%0d]: got %0d want %0d", i, a_y_idx, e.idx); end
            n_checks++; if (a_y_last !== (i == 3)) begin n_fail++; $display("FAIL order_last[%0d]: got %b want %b", i, a_y_last, (i == 3)); end
            n_checks++; if (a_layer_done !== 1'b0) begin n_fail++; $display("FAIL order_done_early[%0d]: got %b want 0", i, a_layer_done); end
            tick();
        end
        n_checks++; if (a_layer_done !== 1'b1) begin n_fail++; $display("FAIL order_done: got %b want 1", a_layer_done); end
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL order_refill_ready: got %b want 1", a_in_ready); end
        tick();
        n_checks++; if (a_layer_done !== 1'b0) begin n_fail++; $display("FAIL order_done_pulse: got %b want 0", a_layer_done); end
    endtask

    task automatic test_backpressure();
        logic [31:0] xs[4];
        logic [15:0] ys[4];
        exp_t        e;
        xs[0] = 32'h1000; xs[1] = 32'h2000; xs[2] = 32'h3000; xs[3] = 32'h4000;
        ys[0] = 16'h10;   ys[1] = 16'h20;   ys[2] = 16'h30;   ys[3] = 16'h40;
        fill_a(xs, ys, 0);
        a_out_ready = 1'b1;
        e = sb.pop_front();
        n_checks++; if (a_y !== e.y) begin n_fail++; $display("FAIL bp_y0: got %h want %h", a_y, e.y); end
        tick();
        a_out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (a_valid_out !== 1'b1 || a_y !== sb[0].y || a_y_idx !== 2'(sb[0].idx) || a_y_last !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b y=%h idx=%0d last=%b want v=1 y=%h idx=%0d last=0",
                         k, a_valid_out, a_y, a_y_idx, a_y_last, sb[0].y, sb[0].idx);
            end
        end
        a_out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            e = sb.pop_front();
            n_checks++;
            if (a_valid_out !== 1'b1 || a_y !== e.y || a_y_idx !== 2'(e.idx)) begin
                n_fail++;
                $display("FAIL bp_release[%0d]: got v=%b y=%h idx=%0d want v=1 y=%h idx=%0d", i, a_valid_out, a_y, a_y_idx, e.y, e.idx);
            end
            tick();
        end
        n_checks++; if (a_layer_done !== 1'b1 || a_valid_out !== 1'b0) begin n_fail++; $display("FAIL bp_end: got done=%b v=%b want done=1 v=0", a_layer_done, a_valid_out); end
    endtask

    task automatic test_input_during_drain();
        logic [31:0] xs[4];
        logic [15:0] ys[4];
        exp_t        e;
        xs[0] = 32'h500; xs[1] = 32'h600; xs[2] = 32'h700; xs[3] = 32'h800;
        ys[0] = 16'd5;   ys[1] = 16'd6;   ys[2] = 16'd7;   ys[3] = 16'd8;
        fill_a(xs, ys, 0);
        a_valid_in  = 1'b1;
        a_x         = 32'h0000_0100;
        a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e = sb.pop_front();
            n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL idd_in_ready[%0d]: got %b want 0", i, a_in_ready); end
            n_checks++; if (a_y !== e.y || a_y_idx !== 2'(e.idx)) begin n_fail++; $display("FAIL idd_y[%0d]: got %h/%0d want %h/%0d", i, a_y, a_y_idx, e.y, e.idx); end
            tick();
        end
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL idd_ready_return: got %b want 1", a_in_ready); end
        sb.push_back('{y: 16'd1, idx: 0});
        tick();
        a_valid_in = 1'b0;
        xs[1] = 32'h900; xs[2] = 32'hA00; xs[3] = 32'hB00;
        ys[1] = 16'd9;   ys[2] = 16'd10;  ys[3] = 16'd11;
        fill_a(xs, ys, 1);
        for (int i = 0; i < 4; i++) begin
            e = sb.pop_front();
            n_checks++;
            if (a_valid_out !== 1'b1 || a_y !== e.y || a_y_idx !== 2'(e.idx)) begin
                n_fail++;
                $display("FAIL idd_next_layer[%0d]: got v=%b y=%h idx=%0d want v=1 y=%h idx=%0d", i, a_valid_out, a_y, a_y_idx, e.y, e.idx);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [31:0] xs[4];
        logic [15:0] ys[4];
        exp_t        e;
        xs[0] = 32'hC00; xs[1] = 32'hD00; xs[2] = 32'hE00; xs[3] = 32'hF00;
        ys[0] = 16'd12;  ys[1] = 16'd13;  ys[2] = 16'd14;  ys[3] = 16'd15;
        fill_a(xs, ys, 0);
        a_out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            e = sb.pop_front();
            n_checks++; if (a_y !== e.y || a_y_idx !== 2'(e.idx)) begin n_fail++; $display("FAIL rmd_pre[%0d]: got %h/%0d want %h/%0d", i, a_y, a_y_idx, e.y, e.idx); end
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        n_checks++; if (a_valid_out !== 1'b0) begin n_fail++; $display("FAIL rmd_valid_out: got %b want 0", a_valid_out); end
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rmd_in_ready: got %b want 1", a_in_ready); end
        n_checks++; if (a_layer_done !== 1'b0) begin n_fail++; $display("FAIL rmd_layer_done: got %b want 0", a_layer_done); end
        xs[0] = 32'h2100; xs[1] = 32'h2200; xs[2] = 32'h2300; xs[3] = 32'h2400;
        ys[0] = 16'h21;   ys[1] = 16'h22;   ys[2] = 16'h23;   ys[3] = 16'h24;
        fill_a(xs, ys, 0);
        for (int i = 0; i < 4; i++) begin
            e = sb.pop_front();
            n_checks++;
            if (a_valid_out !== 1'b1 || a_y !== e.y || a_y_idx !== 2'(e.idx)) begin
                n_fail++;
                $display("FAIL rmd_fresh[%0d]: got v=%b y=%h idx=%0d want v=1 y=%h idx=%0d", i, a_valid_out, a_y, a_y_idx, e.y, e.idx);
            end
            tick();
        end
        n_checks++; if (a_layer_done !== 1'b1 || a_valid_out !== 1'b0) begin n_fail++; $display("FAIL rmd_end: got done=%b v=%b want done=1 v=0", a_layer_done, a_valid_out); end
    endtask

    task automatic test_signed();
        logic [31:0] xs[4];
        logic [15:0] ys[4];
        xs[0] = 32'h8000_0000; xs[1] = 32'hFFFF_8000; xs[2] = 32'h0001_2345; xs[3] = 32'hFFFF_FFFB;
        ys[0] = 16'h8000;      ys[1] = 16'h8000;      ys[2] = 16'h7FFF;      ys[3] = 16'hFFFB;
        for (int i = 0; i < 4; i++) begin
            b_valid_in = 1'b1;
            b_x        = xs[i];
            n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL signed_in_ready[%0d]: got %b want 1", i, b_in_ready); end
            tick();
        end
        b_valid_in  = 1'b0;
        b_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (b_valid_out !== 1'b1 || b_y !== ys[i] || b_y_idx !== 2'(i)) begin
                n_fail++;
                $display("FAIL signed_y[%0d]: got v=%b y=%h idx=%0d want v=1 y=%h idx=%0d", i, b_valid_out, b_y, b_y_idx, ys[i], i);
            end
            tick();
        end
        b_out_ready = 1'b0;
    endtask

    task automatic test_single_node();
        logic [31:0] xs[2];
        logic [15:0] ys[2];
        xs[0] = 32'hFFFF_FFF0; xs[1] = 32'h0000_0040;
        ys[0] = 16'h0000;      ys[1] = 16'h0040;
        c_out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            c_valid_in = 1'b1;
            c_x        = xs[i];
            n_checks++; if (c_in_ready !== 1'b1) begin n_fail++; $display("FAIL n1_in_ready[%0d]: got %b want 1", i, c_in_ready); end
            tick();
            c_valid_in = 1'b0;
            n_checks++;
            if (c_valid_out !== 1'b1 || c_y_last !== 1'b1 || c_y !== ys[i] || c_y_idx !== 1'b0) begin
                n_fail++;
                $display("FAIL n1_beat[%0d]: got v=%b last=%b y=%h idx=%0d want v=1 last=1 y=%h idx=0", i, c_valid_out, c_y_last, c_y, c_y_idx, ys[i]);
            end
            tick();
            n_checks++;
            if (c_layer_done !== 1'b1 || c_valid_out !== 1'b0) begin
                n_fail++;
                $display("FAIL n1_done[%0d]: got done=%b v=%b want done=1 v=0", i, c_layer_done, c_valid_out);
            end
        end
        c_out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int   n_in;
        int   n_out;
        int   n_done;
        int   last_cyc[$];
        bit   acc;
        exp_t e;
        n_in = 0; n_out = 0; n_done = 0;
        a_valid_in  = 1'b1;
        a_out_ready = 1'b1;
        a_x         = 32'hFFFF_F000;
        for (int cyc = 0; cyc < 27; cyc++) begin
            acc = 1'b0;
            if (a_layer_done) n_done++;
            if (a_valid_in && a_in_ready) begin
                sb.push_back('{y: model_act(a_x, 8, 1'b1), idx: n_in % 4});
                n_in++;
                acc = 1'b1;
            end
            if (a_valid_out && a_out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL b2b_extra_output: y=%h idx=%0d with nothing expected", a_y, a_y_idx);
                end else begin
                    e = sb.pop_front();
                    n_checks++;
                    if (a_y !== e.y || a_y_idx !== 2'(e.idx)) begin
                        n_fail++;
                        $display("FAIL b2b_y[%0d]: got %h/%0d want %h/%0d", n_out, a_y, a_y_idx, e.y, e.idx);
                    end
                end
                if (a_y_last) last_cyc.push_back(cyc);
                n_out++;
            end
            tick();
            if (acc) begin
                if (n_in == 12) a_valid_in = 1'b0;
                else a_x = a_x + 32'h0000_0370;
            end
        end
        n_checks++; if (n_in != 12) begin n_fail++; $display("FAIL b2b_inputs: got %0d want 12", n_in); end
        n_checks++; if (n_out != 12) begin n_fail++; $display("FAIL b2b_outputs: got %0d want 12", n_out); end
        n_checks++; if (n_done != 3) begin n_fail++; $display("FAIL b2b_layer_done: got %0d want 3", n_done); end
        n_checks++;
        if (last_cyc.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_layer_timing: got %0d last beats want 3", last_cyc.size());
        end else if (last_cyc[0] != 7 || last_cyc[1] != 15 || last_cyc[2] != 23) begin
            n_fail++;
            $display("FAIL b2b_layer_timing: last beats at %0d,%0d,%0d want 7,15,23", last_cyc[0], last_cyc[1], last_cyc[2]);
        end
        a_out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        a_valid_in = 1'b0; a_x = '0; a_out_ready = 1'b0;
        b_valid_in = 1'b0; b_x = '0; b_out_ready = 1'b0;
        c_valid_in = 1'b0; c_x = '0; c_out_ready = 1'b0;
        test_reset();
        test_requant_order();
        test_backpressure();
        test_input_during_drain();
        test_reset_mid_drain();
        test_signed();
        test_single_node();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
